// File: rtl/cor_h_x.sv
// Backward-filtered target dn[i] = sum x[j]*h[j-i] with ETSI saturating ops,
// followed by block normalisation so that |dn| < 8192, all via shared scratch RAM.
module cor_h_x #(
  parameter logic [11:0] H_ADDR   = 12'd0,
  parameter logic [11:0] X_ADDR   = 12'd64,
  parameter logic [11:0] Y32_ADDR = 12'd128,
  parameter logic [11:0] DN_ADDR  = 12'd192,
  parameter int          L_SUBFR  = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] memIn,
  output logic [11:0] memReadAddr,
  output logic [11:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        memWriteEn,
  output logic        done
);

  localparam int             CW   = $clog2(L_SUBFR);
  localparam logic [CW-1:0]  LAST = CW'(L_SUBFR - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_INIT  = 4'd1;
  localparam logic [3:0] S_RD_X  = 4'd2;
  localparam logic [3:0] S_RD_H  = 4'd3;
  localparam logic [3:0] S_MAC   = 4'd4;
  localparam logic [3:0] S_ST_Y  = 4'd5;
  localparam logic [3:0] S_NORM  = 4'd6;
  localparam logic [3:0] S_SC_RD = 4'd7;
  localparam logic [3:0] S_SC_WR = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic [31:0]   s_q, s_d;
  logic [31:0]   max_q, max_d;
  logic [15:0]   x_q, x_d;
  logic [4:0]    sh_q, sh_d;

  logic [4:0]    norm_n;
  logic [31:0]   s_abs;
  logic [15:0]   dn_lo;

  // (a*b)<<1, with the single overflowing case -32768*-32768 clamped.
  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] ae;
    logic signed [31:0] be;
    logic signed [31:0] p;
    if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
    ae = {{16{a[15]}}, a};
    be = {{16{b[15]}}, b};
    p  = ae * be;
    return p <<< 1;
  endfunction

  function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    if (sum[32] != sum[31]) return sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return sum[31:0];
  endfunction

  function automatic logic [31:0] l_abs(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h7FFF_FFFF;
    return a[31] ? -a : a;
  endfunction

  assign s_abs = l_abs(s_q);
  assign dn_lo = 16'($signed(memIn) >>> sh_q);

  // norm_l of a non-negative value: shifts needed to bring the top one to bit 30.
  always_comb begin
    norm_n = 5'd0;
    for (int k = 0; k < 31; k++) begin
      if (max_q[k]) norm_n = 5'(30 - k);
    end
  end

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    s_d          = s_q;
    max_d        = max_q;
    x_d          = x_q;
    sh_d         = sh_q;
    memReadAddr  = '0;
    memWriteAddr = '0;
    memOut       = '0;
    memWriteEn   = 1'b0;
    done         = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        i_d     = '0;
        j_d     = '0;
        s_d     = '0;
        max_d   = '0;
        state_d = S_RD_X;
      end
      S_RD_X: begin
        memReadAddr = X_ADDR + 12'(j_q);
        state_d     = S_RD_H;
      end
      S_RD_H: begin
        x_d         = memIn[15:0];
        memReadAddr = H_ADDR + 12'(j_q - i_q);
        state_d     = S_MAC;
      end
      S_MAC: begin
        s_d = l_add(s_q, l_mult(x_q, memIn[15:0]));
        // The next x fetch is issued here so each tap costs two cycles.
        if (j_q == LAST) begin
          state_d = S_ST_Y;
        end else begin
          j_d         = j_q + CW'(1);
          memReadAddr = X_ADDR + 12'(j_q + CW'(1));
          state_d     = S_RD_H;
        end
      end
      S_ST_Y: begin
        memWriteEn   = 1'b1;
        memWriteAddr = Y32_ADDR + 12'(i_q);
        memOut       = s_q;
        if (s_abs > max_q) max_d = s_abs;
        if (i_q == LAST) begin
          i_d     = '0;
          state_d = S_NORM;
        end else begin
          i_d     = i_q + CW'(1);
          j_d     = i_q + CW'(1);
          s_d     = '0;
          state_d = S_RD_X;
        end
      end
      S_NORM: begin
        sh_d    = (norm_n > 5'd16) ? 5'd2 : 5'd18 - norm_n;
        state_d = S_SC_RD;
      end
      S_SC_RD: begin
        memReadAddr = Y32_ADDR + 12'(i_q);
        state_d     = S_SC_WR;
      end
      S_SC_WR: begin
        memWriteEn   = 1'b1;
        memWriteAddr = DN_ADDR + 12'(i_q);
        memOut       = {{16{dn_lo[15]}}, dn_lo};
        if (i_q == LAST) begin
          i_d     = '0;
          state_d = S_DONE;
        end else begin
          i_d     = i_q + CW'(1);
          state_d = S_SC_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      s_q     <= '0;
      max_q   <= '0;
      x_q     <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      s_q     <= s_d;
      max_q   <= max_d;
      x_q     <= x_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: tb/tb_cor_h_x.sv
// Scoreboard bench for cor_h_x: expected scratch writes are queued per run and
// a negedge monitor pops and compares every write the DUT issues.
module tb_cor_h_x;

  localparam logic [11:0] H_BASE  = 12'd0;
  localparam logic [11:0] X_BASE  = 12'd64;
  localparam logic [11:0] Y_BASE  = 12'd128;
  localparam logic [11:0] DN_BASE = 12'd192;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] memIn;
  logic [11:0] memReadAddr;
  logic [11:0] memWriteAddr;
  logic [31:0] memOut;
  logic        memWriteEn;
  logic        done;

  always #5 clk = ~clk;

  cor_h_x dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .memIn       (memIn),
    .memReadAddr (memReadAddr),
    .memWriteAddr(memWriteAddr),
    .memOut      (memOut),
    .memWriteEn  (memWriteEn),
    .done        (done)
  );

  // Scratch RAM with one-cycle read latency; the bench preloads through tb_we.
  logic [31:0] mem [0:4095];
  logic        tb_we = 1'b0;
  logic [11:0] tb_addr = '0;
  logic [31:0] tb_data = '0;

  always @(posedge clk) begin
    memIn <= mem[memReadAddr];
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (memWriteEn) mem[memWriteAddr] <= memOut;
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  wr_t  sb_q[$];
  wr_t  trace_q[$];
  wr_t  trace_b[$];
  wr_t  exp_wr;
  logic rec = 1'b0;

  logic [15:0] xv [40];
  logic [15:0] hv [40];
  logic [31:0] ey [40];
  logic [31:0] ed [40];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (memWriteEn) begin
      if (rec) trace_q.push_back(wr_t'{memWriteAddr, memOut});
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: actual addr=%h data=%h required=no write",
                 memWriteAddr, memOut);
      end else begin
        exp_wr = sb_q.pop_front();
        check($sformatf("write@%0h", exp_wr.addr),
              {20'b0, memWriteAddr, memOut}, {20'b0, exp_wr.addr, exp_wr.data});
      end
    end
  end

  task automatic mem_wr(input logic [11:0] a, input logic [31:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  task automatic load_mem();
    for (int k = 0; k < 40; k++) begin
      mem_wr(H_BASE + 12'(k), {{16{hv[k][15]}}, hv[k]});
      mem_wr(X_BASE + 12'(k), {{16{xv[k][15]}}, xv[k]});
    end
  endtask

  task automatic push_exp();
    for (int i = 0; i < 40; i++) sb_q.push_back(wr_t'{Y_BASE + 12'(i), ey[i]});
    for (int i = 0; i < 40; i++) sb_q.push_back(wr_t'{DN_BASE + 12'(i), ed[i]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge of the done cycle, or after the cycle budget expires.
  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && cyc < 2100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_in_budget"}, 64'(done && cyc <= 2000), 64'd1);
  endtask

  task automatic run(input string name);
    int d0;
    d0 = done_cnt;
    push_exp();
    pulse_start();
    wait_done(name);
    @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_all_writes"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic set_impulse_ramp();
    for (int k = 0; k < 40; k++) begin
      hv[k] = (k == 0) ? 16'sd8192 : 16'sd0;
      xv[k] = 16'(100 * k);
      ey[k] = 32'(16384 * 100 * k);
      ed[k] = 32'(200 * k);
    end
  endtask

  initial begin
    int d0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {6'b0, memReadAddr, memWriteAddr, memOut, memWriteEn, done}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // x all zero, arbitrary h
    for (int k = 0; k < 40; k++) begin
      xv[k] = 16'd0;
      hv[k] = 16'(k * 37 - 500);
      ey[k] = 32'd0;
      ed[k] = 32'd0;
    end
    load_mem();
    run("zero_x");

    // Unit impulse (8192) against a ramp: sh = 13, dn[i] = 200*i
    set_impulse_ramp();
    load_mem();
    run("ramp");

    // Single negative sample: sh = 11, dn[5] = -8000
    for (int k = 0; k < 40; k++) begin
      xv[k] = 16'd0;
      ey[k] = 32'd0;
      ed[k] = 32'd0;
    end
    xv[5] = 16'(-1000);
    ey[5] = 32'(-16384000);
    ed[5] = 32'hFFFF_E0C0;
    load_mem();
    run("single_neg");

    // Every product and every sum saturates
    for (int k = 0; k < 40; k++) begin
      xv[k] = 16'h8000;
      hv[k] = 16'h8000;
      ey[k] = 32'h7FFF_FFFF;
      ed[k] = 32'd8191;
    end
    load_mem();
    run("saturate");

    // Reset 500 cycles into a run aborts it with no further writes or done
    set_impulse_ramp();
    load_mem();
    d0 = done_cnt;
    push_exp();
    pulse_start();
    repeat (499) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {6'b0, memReadAddr, memWriteAddr, memOut, memWriteEn, done}, 64'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run("rerun_after_reset");

    // Extra starts mid-run and during the done cycle are ignored
    d0 = done_cnt;
    push_exp();
    pulse_start();
    repeat (100) @(posedge clk);
    #1 pulse_start();
    repeat (800) @(posedge clk);
    #1 pulse_start();
    wait_done("extra_start");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("extra_start_all_writes", 64'(sb_q.size()), 64'd0);
    repeat (60) @(posedge clk);
    #1;
    check("start_at_done_ignored", 64'(done_cnt - d0), 64'd1);

    // Back-to-back: start in the cycle right after done gives an identical trace
    trace_q.delete();
    rec = 1'b1;
    d0 = done_cnt;
    push_exp();
    pulse_start();
    wait_done("b2b_first");
    @(posedge clk);
    #1;
    check("b2b_first_done_once", 64'(done_cnt - d0), 64'd1);
    check("b2b_first_all_writes", 64'(sb_q.size()), 64'd0);
    trace_b = trace_q;
    trace_q.delete();
    d0 = done_cnt;
    push_exp();
    pulse_start();
    wait_done("b2b_second");
    @(posedge clk);
    #1;
    rec = 1'b0;
    check("b2b_second_done_once", 64'(done_cnt - d0), 64'd1);
    check("b2b_second_all_writes", 64'(sb_q.size()), 64'd0);
    check("trace_len", 64'(trace_q.size()), 64'd80);
    for (int i = 0; i < trace_q.size() && i < trace_b.size(); i++)
      check($sformatf("trace_%0d", i), {20'b0, trace_q[i]}, {20'b0, trace_b[i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
